// File: rtl/cpu_pkg.sv
// Shared CPU package: default writeback geometry, the null destination tag and
// the source-select encoding for the MEM/WB main stage.
package cpu_pkg;

  localparam int unsigned WB_LANES_DEF = 4;
  localparam int unsigned WB_DW_DEF    = 16;
  localparam int unsigned WB_TW_DEF    = 5;
  localparam int unsigned TAG_NONE     = 0;
  localparam logic [15:0] STALL_MAX    = 16'hFFFF;

  typedef enum logic [1:0] {
    SRC_HOLD  = 2'd0,
    SRC_INPUT = 2'd1,
    SRC_SKID  = 2'd2,
    SRC_CLEAR = 2'd3
  } wb_src_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == STALL_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/wb_lane_reg.sv
// One writeback lane slot holding valid/data/tag. Flush and clear only drop the
// valid bit; the payload registers keep their contents until the next load.
module wb_lane_reg #(
  parameter int unsigned DW = 16,
  parameter int unsigned TW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          load_i,
  input  logic          clear_i,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  input  logic [TW-1:0] tag_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic [TW-1:0] tag_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic [TW-1:0] tag_q, tag_d;

  // Next-state selection: flush beats load, load beats clear.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    tag_d   = tag_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = valid_i;
      data_d  = data_i;
      tag_d   = tag_i;
    end else if (clear_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Lane state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register: null-tag lane masking, flush, saturating stall counter.
// Define MEM_WB_SKID_EN to add a skid stage so in_ready comes straight from a flop.
module mem_wb_pipe
  import cpu_pkg::*;
#(
  parameter int unsigned LANES = WB_LANES_DEF,
  parameter int unsigned DW    = WB_DW_DEF,
  parameter int unsigned TW    = WB_TW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LANES-1:0]    in_valid,
  input  logic [LANES*DW-1:0] in_data,
  input  logic [LANES*TW-1:0] in_tag,
  output logic                in_ready,
  input  logic                flush,
  input  logic                out_ready,
  output logic [LANES-1:0]    out_valid,
  output logic [LANES*DW-1:0] out_data,
  output logic [LANES*TW-1:0] out_tag,
  output logic [15:0]         stall_cnt
);

  logic [LANES-1:0]    keep_s;
  logic                push_s;
  logic                pop_s;
  logic                main_full_s;
  logic                main_load_s;
  logic                main_clear_s;
  wb_src_e             main_src_s;
  logic [LANES-1:0]    main_vin_s;
  logic [LANES*DW-1:0] main_din_s;
  logic [LANES*TW-1:0] main_tin_s;
  logic [15:0]         stall_q, stall_d;

  for (genvar i = 0; i < LANES; i++) begin : g_keep
    assign keep_s[i] = in_valid[i] && (in_tag[i*TW +: TW] != TW'(TAG_NONE));
  end

  assign main_full_s  = |out_valid;
  assign pop_s        = out_ready && main_full_s;
  assign push_s       = in_ready && (|in_valid);
  assign main_load_s  = (main_src_s == SRC_INPUT) || (main_src_s == SRC_SKID);
  assign main_clear_s = (main_src_s == SRC_CLEAR);

`ifdef MEM_WB_SKID_EN
  logic [LANES-1:0]    skid_valid_s;
  logic [LANES*DW-1:0] skid_data_s;
  logic [LANES*TW-1:0] skid_tag_s;
  logic                skid_full_s;
  logic                skid_load_s;
  logic                skid_clear_s;
  logic                in_ready_q, in_ready_d;

  assign skid_full_s  = |skid_valid_s;
  assign skid_load_s  = !flush && push_s && main_full_s && !pop_s;
  assign skid_clear_s = !flush && pop_s && skid_full_s;
  assign in_ready     = in_ready_q;

  // Main stage refills from the skid first so older groups always leave first.
  always_comb begin
    main_src_s = SRC_HOLD;
    if (flush) begin
      main_src_s = SRC_HOLD;
    end else if (pop_s && skid_full_s) begin
      main_src_s = SRC_SKID;
    end else if (push_s && (!main_full_s || pop_s)) begin
      main_src_s = SRC_INPUT;
    end else if (pop_s) begin
      main_src_s = SRC_CLEAR;
    end else begin
      main_src_s = SRC_HOLD;
    end
  end

  // in_ready tracks "skid will be empty"; a fully masked group never occupies it.
  always_comb begin
    in_ready_d = in_ready_q;
    if (flush) begin
      in_ready_d = 1'b1;
    end else if (skid_load_s) begin
      in_ready_d = !(|keep_s);
    end else if (skid_clear_s) begin
      in_ready_d = 1'b1;
    end else begin
      in_ready_d = in_ready_q;
    end
  end

  // Registered ready flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= in_ready_d;
    end
  end

  assign main_vin_s = (main_src_s == SRC_SKID) ? skid_valid_s : keep_s;
  assign main_din_s = (main_src_s == SRC_SKID) ? skid_data_s  : in_data;
  assign main_tin_s = (main_src_s == SRC_SKID) ? skid_tag_s   : in_tag;

  for (genvar i = 0; i < LANES; i++) begin : g_skid
    wb_lane_reg #(.DW(DW), .TW(TW)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .flush_i (flush),
      .load_i  (skid_load_s),
      .clear_i (skid_clear_s),
      .valid_i (keep_s[i]),
      .data_i  (in_data[i*DW +: DW]),
      .tag_i   (in_tag[i*TW +: TW]),
      .valid_o (skid_valid_s[i]),
      .data_o  (skid_data_s[i*DW +: DW]),
      .tag_o   (skid_tag_s[i*TW +: TW])
    );
  end
`else
  assign in_ready = !main_full_s || out_ready;

  // Single stage: a push always lands in main, replacing a group that pops this cycle.
  always_comb begin
    main_src_s = SRC_HOLD;
    if (flush) begin
      main_src_s = SRC_HOLD;
    end else if (push_s) begin
      main_src_s = SRC_INPUT;
    end else if (pop_s) begin
      main_src_s = SRC_CLEAR;
    end else begin
      main_src_s = SRC_HOLD;
    end
  end

  assign main_vin_s = keep_s;
  assign main_din_s = in_data;
  assign main_tin_s = in_tag;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_main
    wb_lane_reg #(.DW(DW), .TW(TW)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .flush_i (flush),
      .load_i  (main_load_s),
      .clear_i (main_clear_s),
      .valid_i (main_vin_s[i]),
      .data_i  (main_din_s[i*DW +: DW]),
      .tag_i   (main_tin_s[i*TW +: TW]),
      .valid_o (out_valid[i]),
      .data_o  (out_data[i*DW +: DW]),
      .tag_o   (out_tag[i*TW +: TW])
    );
  end

  // Stall counter next state; a flush cycle is not counted as a stall.
  always_comb begin
    stall_d = stall_q;
    if (main_full_s && !out_ready && !flush) begin
      stall_d = sat_inc16(stall_q);
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe: directed scenarios plus random traffic against a group-queue model.
// The model's capacity follows MEM_WB_SKID_EN (two groups with skid, one without).
`timescale 1ns/1ps
module tb_mem_wb_pipe;

  localparam int L  = 4;
  localparam int DW = 16;
  localparam int TW = 5;
`ifdef MEM_WB_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  localparam logic [L*DW-1:0] A_D = 64'hAAAA_1111_2222_3333;
  localparam logic [L*TW-1:0] A_T = {5'd1, 5'd2, 5'd3, 5'd4};
  localparam logic [L*DW-1:0] B_D = 64'hBBBB_4444_5555_6666;
  localparam logic [L*TW-1:0] B_T = {5'd5, 5'd6, 5'd7, 5'd8};
  localparam logic [L*DW-1:0] C_D = 64'hCCCC_7777_8888_9999;
  localparam logic [L*TW-1:0] C_T = {5'd10, 5'd0, 5'd11, 5'd12};

  logic            clk = 1'b0;
  logic            rst;
  logic [L-1:0]    in_valid;
  logic [L*DW-1:0] in_data;
  logic [L*TW-1:0] in_tag;
  logic            in_ready;
  logic            flush;
  logic            out_ready;
  logic [L-1:0]    out_valid;
  logic [L*DW-1:0] out_data;
  logic [L*TW-1:0] out_tag;
  logic [15:0]     stall_cnt;

  always #5 clk = ~clk;

  mem_wb_pipe #(.LANES(L), .DW(DW), .TW(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .stall_cnt (stall_cnt)
  );

  typedef struct packed {
    logic [L-1:0]    v;
    logic [L*DW-1:0] d;
    logic [L*TW-1:0] t;
  } grp_t;

  grp_t        q[$];
  int unsigned exp_stall;
  int          n_vec;
  int          n_err;

  function automatic logic model_ready();
    if (CAP == 2) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  function automatic logic [L-1:0] model_valid();
    return (q.size() == 0) ? '0 : q[0].v;
  endfunction

  function automatic logic [L-1:0] kept(input logic [L-1:0] v, input logic [L*TW-1:0] t);
    logic [L-1:0] k;
    for (int i = 0; i < L; i++) k[i] = v[i] && (t[i*TW +: TW] != '0);
    return k;
  endfunction

  task automatic drive(input logic [L-1:0] v, input logic [L*DW-1:0] d,
                       input logic [L*TW-1:0] t, input logic f, input logic r);
    in_valid  = v;
    in_data   = d;
    in_tag    = t;
    flush     = f;
    out_ready = r;
    #1;
  endtask

  // Advance one clock, updating the model from the inputs present at the edge.
  task automatic tick();
    logic         push;
    logic         pop;
    logic [L-1:0] k;
    grp_t         g;
    push = model_ready() && (|in_valid);
    pop  = out_ready && (q.size() > 0);
    k    = kept(in_valid, in_tag);
    if (q.size() > 0 && !out_ready && !flush && exp_stall != 32'd65535) exp_stall++;
    if (flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push && k != '0) begin
        g.v = k; g.d = in_data; g.t = in_tag;
        q.push_back(g);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive('0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q.delete();
    exp_stall = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL reset_valid got=%b want=0000", out_valid); end
    n_vec++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL reset_stall got=%h want=0000", stall_cnt); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    n_vec++; if (out_data !== '0 || out_tag !== '0) begin n_err++; $display("FAIL reset_payload data=%h tag=%h want=0", out_data, out_tag); end
  endtask

  task automatic test_mask();
    do_reset();
    drive(4'b1111, {16'd4, 16'd3, 16'd2, 16'd1}, {5'd9, 5'd0, 5'd7, 5'd3}, 1'b0, 1'b1);
    tick();
    drive('0, '0, '0, 1'b0, 1'b1);
    n_vec++; if (out_valid !== 4'b1011) begin n_err++; $display("FAIL mask_valid got=%b want=1011", out_valid); end
    n_vec++; if (out_data[DW +: DW] !== 16'd2) begin n_err++; $display("FAIL mask_lane1_data got=%0d want=2", out_data[DW +: DW]); end
    n_vec++; if (out_tag[3*TW +: TW] !== 5'd9) begin n_err++; $display("FAIL mask_lane3_tag got=%0d want=9", out_tag[3*TW +: TW]); end
    tick();
    n_vec++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL mask_popped got=%b want=0000", out_valid); end
  endtask

  task automatic test_stall();
    do_reset();
    drive(4'b1111, A_D, A_T, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive('0, '0, '0, 1'b0, 1'b0);
      n_vec++;
      if (out_valid !== 4'b1111 || out_data !== A_D || out_tag !== A_T) begin
        n_err++; $display("FAIL stall_hold cyc=%0d got=%b/%h/%h want=1111/%h/%h", i, out_valid, out_data, out_tag, A_D, A_T);
      end
      tick();
    end
    n_vec++; if (stall_cnt !== 16'd5) begin n_err++; $display("FAIL stall_count got=%0d want=5", stall_cnt); end
    drive('0, '0, '0, 1'b0, 1'b1);
    n_vec++; if (out_valid !== 4'b1111) begin n_err++; $display("FAIL stall_release_valid got=%b want=1111", out_valid); end
    tick();
    n_vec++; if (out_valid !== 4'b0000 || stall_cnt !== 16'd5) begin n_err++; $display("FAIL stall_popped got=%b/%0d want=0000/5", out_valid, stall_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
`ifdef MEM_WB_SKID_EN
    drive(4'b1111, A_D, A_T, 1'b0, 1'b0); tick();
    drive(4'b1111, B_D, B_T, 1'b0, 1'b0);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL skid_accept_b got=%b want=1", in_ready); end
    tick();
    drive(4'b1111, C_D, C_T, 1'b0, 1'b0);
    n_vec++; if (in_ready !== 1'b0 || out_data !== A_D) begin n_err++; $display("FAIL skid_block_c ready=%b data=%h want=0/%h", in_ready, out_data, A_D); end
    tick();
    drive(4'b1111, C_D, C_T, 1'b0, 1'b1);
    n_vec++; if (in_ready !== 1'b0 || out_data !== A_D) begin n_err++; $display("FAIL skid_release_a ready=%b data=%h want=0/%h", in_ready, out_data, A_D); end
    tick();
    drive(4'b1111, C_D, C_T, 1'b0, 1'b1);
    n_vec++; if (in_ready !== 1'b1 || out_data !== B_D) begin n_err++; $display("FAIL skid_then_b ready=%b data=%h want=1/%h", in_ready, out_data, B_D); end
    tick();
`else
    drive(4'b1111, A_D, A_T, 1'b0, 1'b0); tick();
    drive(4'b1111, B_D, B_T, 1'b0, 1'b0);
    n_vec++; if (in_ready !== 1'b0 || out_data !== A_D) begin n_err++; $display("FAIL b2b_block ready=%b data=%h want=0/%h", in_ready, out_data, A_D); end
    tick();
    drive(4'b1111, B_D, B_T, 1'b0, 1'b1);
    n_vec++; if (in_ready !== 1'b1 || out_data !== A_D) begin n_err++; $display("FAIL b2b_release ready=%b data=%h want=1/%h", in_ready, out_data, A_D); end
    tick();
    drive(4'b1111, C_D, C_T, 1'b0, 1'b1);
    n_vec++; if (out_data !== B_D) begin n_err++; $display("FAIL b2b_then_b data=%h want=%h", out_data, B_D); end
    tick();
`endif
    drive('0, '0, '0, 1'b0, 1'b1);
    n_vec++; if (out_valid !== 4'b1011 || out_data !== C_D) begin n_err++; $display("FAIL b2b_then_c got=%b/%h want=1011/%h", out_valid, out_data, C_D); end
    tick();
    n_vec++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL b2b_drained got=%b want=0000", out_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(4'b1111, A_D, A_T, 1'b0, 1'b0); tick();
    drive(4'b1111, B_D, B_T, 1'b1, 1'b0); tick();
    drive('0, '0, '0, 1'b0, 1'b1);
    n_vec++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL flush_valid got=%b want=0000", out_valid); end
    n_vec++; if (out_data !== A_D || out_tag !== A_T) begin n_err++; $display("FAIL flush_payload got=%h/%h want=%h/%h", out_data, out_tag, A_D, A_T); end
    n_vec++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL flush_stall got=%0d want=0", stall_cnt); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL flush_ghost cyc=%0d got=%b want=0000", i, out_valid); end
    end
  endtask

  task automatic test_random();
    logic [L-1:0]    v;
    logic [L*TW-1:0] t;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      v = L'($urandom());
      for (int i = 0; i < L; i++)
        t[i*TW +: TW] = ($urandom_range(0, 3) == 0) ? 5'd0 : TW'($urandom_range(1, 31));
      drive(v, {$urandom(), $urandom()}, t, ($urandom_range(0, 31) == 0), ($urandom_range(0, 9) < 7));
      n_vec++; if (in_ready !== model_ready()) begin n_err++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", c, in_ready, model_ready()); end
      n_vec++; if (out_valid !== model_valid()) begin n_err++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", c, out_valid, model_valid()); end
      n_vec++; if (stall_cnt !== exp_stall[15:0]) begin n_err++; $display("FAIL rnd_stall cyc=%0d got=%0d want=%0d", c, stall_cnt, exp_stall); end
      if (q.size() > 0) begin
        n_vec++;
        if (out_data !== q[0].d || out_tag !== q[0].t) begin
          n_err++; $display("FAIL rnd_payload cyc=%0d got=%h/%h want=%h/%h", c, out_data, out_tag, q[0].d, q[0].t);
        end
      end
      tick();
    end
  endtask

  task automatic test_saturate();
    logic [15:0] want;
    do_reset();
    drive(4'b1111, A_D, A_T, 1'b0, 1'b0); tick();
    drive('0, '0, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 65538; i++) begin
      tick();
      if (i == 65534 || i == 65535 || i == 65538) begin
        want = (i >= 65535) ? 16'hFFFF : 16'(i);
        n_vec++; if (stall_cnt !== want || stall_cnt !== exp_stall[15:0]) begin n_err++; $display("FAIL sat_count after=%0d got=%h want=%h", i, stall_cnt, want); end
      end
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    drive(4'b1111, A_D, A_T, 1'b0, 1'b0); tick();
    drive(4'b1111, B_D, B_T, 1'b0, 1'b0); tick();
    drive('0, '0, '0, 1'b0, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    n_vec++; if (out_valid !== 4'b0000 || stall_cnt !== 16'd0) begin n_err++; $display("FAIL rstmid_clear got=%b/%0d want=0000/0", out_valid, stall_cnt); end
    n_vec++; if (out_data !== '0 || out_tag !== '0) begin n_err++; $display("FAIL rstmid_payload got=%h/%h want=0", out_data, out_tag); end
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    exp_stall = 0;
    #1;
    n_vec++; if (in_ready !== 1'b1 || out_valid !== 4'b0000) begin n_err++; $display("FAIL rstmid_release ready=%b valid=%b want=1/0000", in_ready, out_valid); end
    drive(4'b1111, C_D, C_T, 1'b0, 1'b1); tick();
    drive('0, '0, '0, 1'b0, 1'b1);
    n_vec++; if (out_valid !== 4'b1011 || out_data !== C_D) begin n_err++; $display("FAIL rstmid_next got=%b/%h want=1011/%h", out_valid, out_data, C_D); end
    tick();
    n_vec++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL rstmid_no_recovery got=%b want=0000", out_valid); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    exp_stall = 0;
    test_reset();
    test_mask();
    test_stall();
    test_back_to_back();
    test_flush();
    test_random();
    test_saturate();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
